stage_1_fetch: RTL and testbench
================================

Name: stage_1_fetch

Overview:
Pipeline stage 1. Owns the program counter and issues in-order requests to instruction memory over a req/ready + rvalid interface. Buffers returned words in a small queue and presents one registered instruction/PC pair per cycle to the decode stage. Honours the decode-stage stall and redirects from the jump/branch resolution stage, discarding wrong-path responses still in flight.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
QUEUE_DEPTH, 2, instruction queue entries; also the cap on outstanding requests plus queued words (power of two, >=2).
NOP_INSN, 32'h0000_0013, word presented when no valid instruction (addi x0,x0,0).

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
stall_in  in  1  decode requests hold; outputs must not advance.
redirect_valid  in  1  taken jump/branch; flush and refetch.
redirect_addr  in  32  new PC; bits [1:0] ignored (forced 0).
imem_req  out  1  request valid.
imem_addr  out  32  word-aligned fetch address.
imem_ready  in  1  memory accepts request this cycle (handshake = imem_req & imem_ready).
imem_rvalid  in  1  response valid; responses in request order, >=1 cycle after acceptance.
imem_rdata  in  32  response word.
instruction_out  out  32  registered instruction to decode.
pc_out  out  32  registered PC of instruction_out.
valid_out  out  1  instruction_out is a real fetched instruction.

Behaviour:
- Reset (async, rst_n=0): fetch_pc=RESET_PC, queue empty, outstanding=0, drop=0, imem_req=0, instruction_out=NOP_INSN, pc_out=RESET_PC, valid_out=0. Reset mid-transaction abandons in-flight responses; memory is reset by the same rst_n.
- Credit: imem_req=1 iff !redirect_valid and (queue_count + outstanding) < QUEUE_DEPTH. imem_addr=fetch_pc, combinational from registers.
- Accept (imem_req & imem_ready): outstanding+1, fetch_pc+=4 (32-bit wrap, 0xFFFF_FFFC -> 0). If not accepted, imem_req/imem_addr stay stable unless a redirect intervenes.
- Response: if drop>0, drop-1 and word discarded; else push {pc, rdata} to queue (pc tracked by response-PC register, +4 per push). outstanding-1 in both cases. Accept and response in the same cycle: outstanding unchanged.
- Output advance when !stall_in: if queue non-empty, pop to outputs, valid_out=1; else outputs = NOP_INSN, valid_out=0, pc_out unchanged. Pop and push in same cycle allowed; a push into an empty queue reaches outputs one cycle later (no bypass). Min latency acceptance->valid_out: 2 cycles after rvalid edge... precisely: rvalid at cycle N -> queue N+1 -> outputs at edge N+2.
- stall_in=1: outputs and queue hold; fetching continues until credit exhausted.
- Redirect (priority over stall and everything else): queue flushed; drop <= outstanding minus (1 if a non-dropped response arrives this cycle, since it is discarded directly); fetch_pc and response-PC <= {redirect_addr[31:2],2'b00}; outputs <= NOP_INSN, valid_out=0. No request issued that cycle. New requests begin next cycle; they are accepted only after credit permits, so drop count never exceeds QUEUE_DEPTH.
- Back-to-back redirects: second overrides first; drop accumulates correctly (remaining outstanding all dropped).
- Queue full with rvalid cannot occur by credit rule; assertion required in bench.

Decomposition:
- Shared package: FetchEntry struct {Addr pc; Data insn}; NOP_INSN constant; reuse existing Data/Addr/Bool typedefs.
- One sub-module: fetch_queue (synchronous FIFO, QUEUE_DEPTH entries of FetchEntry, push/pop/flush, count, async active-low reset).

Test Plan:
- Reset, imem_ready=1, 1-cycle latency, stall_in=0 -> imem_addr 0,4,8,... ; valid_out rises, pc_out 0,4,8 with matching rdata, one per cycle steady state.
- stall_in=1 for 4 cycles mid-stream -> outputs held; imem_req drops after QUEUE_DEPTH words in flight/queued; after release sequence continues without loss or duplication.
- redirect_valid with redirect_addr=0x103 while 2 requests outstanding -> both responses discarded, next imem_addr=0x100, first valid_out has pc_out=0x100.
- imem_ready toggling 1/0 and 3-cycle response latency -> in-order delivery, imem_addr stable while unaccepted, no queue overflow.
- PC at 0xFFFF_FFF8, fetch 3 words -> addresses 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
- rst_n asserted with requests outstanding -> outputs immediately NOP_INSN/RESET_PC/valid_out=0; post-reset fetch resumes at RESET_PC.

Source files
------------

// File: rtl/stage_1_fetch_pkg.sv
// Shared types and constants for the stage-1 fetch unit.
// Fetched words travel with their PC as a single FetchEntry.
package stage_1_fetch_pkg;

    typedef logic [31:0] Data;
    typedef logic [31:0] Addr;
    typedef logic        Bool;

    typedef struct packed {
        Addr pc;
        Data insn;
    } FetchEntry;

    localparam Data NOP_INSN = 32'h0000_0013;
    localparam Addr PC_STEP  = 32'd4;

    function automatic Addr align_pc(input Addr a);
        return {a[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/stage_1_fetch_queue.sv
// Small synchronous FIFO of fetched {pc, insn} entries.
// Flush empties it in one cycle; the caller never pushes when full or pops when empty.
module fetch_queue
    import stage_1_fetch_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  FetchEntry        push_data,
    input  logic             pop,
    input  logic             flush,
    output FetchEntry        head,
    output logic [CNT_W-1:0] count
);

    FetchEntry        mem_reg [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic [CNT_W-1:0] count_next;

    assign count_next = count_reg + CNT_W'(push) - CNT_W'(pop);

    // Storage needs no reset: count_reg alone says which slots are meaningful.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem_reg[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            count_reg <= count_next;
        end
    end

    assign head  = mem_reg[rd_ptr_reg];
    assign count = count_reg;

endmodule

// File: rtl/stage_1_fetch.sv
// Pipeline stage 1: owns the PC, issues in-order imem requests under a credit limit,
// buffers responses and hands one registered instruction per cycle to decode.
module stage_1_fetch
    import stage_1_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          QUEUE_DEPTH = 2,
    parameter logic [31:0] NOP_INSN    = stage_1_fetch_pkg::NOP_INSN
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall_in,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_addr,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instruction_out,
    output logic [31:0] pc_out,
    output logic        valid_out
);

    localparam int CNT_W = $clog2(QUEUE_DEPTH) + 1;

    Addr              fetch_pc_reg, fetch_pc_next;
    Addr              resp_pc_reg, resp_pc_next;
    logic [CNT_W-1:0] outstanding_reg, outstanding_next;
    logic [CNT_W-1:0] drop_reg, drop_next;
    Data              insn_reg, insn_next;
    Addr              pc_out_reg, pc_out_next;
    logic             valid_reg, valid_next;

    FetchEntry        q_head;
    FetchEntry        q_push_data;
    logic [CNT_W-1:0] q_count;
    logic             q_push, q_pop;
    logic             credit, accept, resp_drop;

    // Outstanding requests and queued words together may never exceed the queue size,
    // so every response is guaranteed a slot.
    assign credit    = ({1'b0, q_count} + {1'b0, outstanding_reg}) < (CNT_W + 1)'(QUEUE_DEPTH);
    assign imem_req  = rst_n && !redirect_valid && credit;
    assign imem_addr = fetch_pc_reg;
    assign accept    = imem_req && imem_ready;

    assign resp_drop   = imem_rvalid && (drop_reg != '0);
    assign q_push      = imem_rvalid && !resp_drop && !redirect_valid;
    assign q_pop       = !redirect_valid && !stall_in && (q_count != '0);
    assign q_push_data = '{pc: resp_pc_reg, insn: imem_rdata};

    fetch_queue #(.DEPTH(QUEUE_DEPTH)) u_queue (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (q_push),
        .push_data (q_push_data),
        .pop       (q_pop),
        .flush     (redirect_valid),
        .head      (q_head),
        .count     (q_count)
    );

    always_comb begin
        fetch_pc_next    = fetch_pc_reg;
        resp_pc_next     = resp_pc_reg;
        outstanding_next = outstanding_reg + CNT_W'(accept) - CNT_W'(imem_rvalid);
        drop_next        = drop_reg;
        insn_next        = insn_reg;
        pc_out_next      = pc_out_reg;
        valid_next       = valid_reg;

        if (resp_drop) drop_next     = drop_reg - 1'b1;
        if (accept)    fetch_pc_next = fetch_pc_reg + PC_STEP;
        if (q_push)    resp_pc_next  = resp_pc_reg + PC_STEP;

        if (redirect_valid) begin
            // Everything still in flight after this edge belongs to the wrong path.
            fetch_pc_next = align_pc(redirect_addr);
            resp_pc_next  = align_pc(redirect_addr);
            drop_next     = outstanding_reg - CNT_W'(imem_rvalid);
            insn_next     = NOP_INSN;
            valid_next    = 1'b0;
        end else if (!stall_in) begin
            if (q_count != '0) begin
                insn_next   = q_head.insn;
                pc_out_next = q_head.pc;
                valid_next  = 1'b1;
            end else begin
                insn_next  = NOP_INSN;
                valid_next = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_reg    <= RESET_PC;
            resp_pc_reg     <= RESET_PC;
            outstanding_reg <= '0;
            drop_reg        <= '0;
            insn_reg        <= NOP_INSN;
            pc_out_reg      <= RESET_PC;
            valid_reg       <= 1'b0;
        end else begin
            fetch_pc_reg    <= fetch_pc_next;
            resp_pc_reg     <= resp_pc_next;
            outstanding_reg <= outstanding_next;
            drop_reg        <= drop_next;
            insn_reg        <= insn_next;
            pc_out_reg      <= pc_out_next;
            valid_reg       <= valid_next;
        end
    end

    assign instruction_out = insn_reg;
    assign pc_out          = pc_out_reg;
    assign valid_out       = valid_reg;

endmodule

// File: tb/tb_stage_1_fetch.sv
// Self-checking bench for stage_1_fetch: memory model with variable latency,
// program-order scoreboard, directed sequences and a randomized soak.
module tb_stage_1_fetch;

    localparam int          QD  = 2;
    localparam logic [31:0] RPC = 32'h0000_0000;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall_in = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_addr = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic [31:0] instruction_out;
    logic [31:0] pc_out;
    logic        valid_out;

    stage_1_fetch #(.RESET_PC(RPC), .QUEUE_DEPTH(QD), .NOP_INSN(NOP)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .stall_in        (stall_in),
        .redirect_valid  (redirect_valid),
        .redirect_addr   (redirect_addr),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_ready      (imem_ready),
        .imem_rvalid     (imem_rvalid),
        .imem_rdata      (imem_rdata),
        .instruction_out (instruction_out),
        .pc_out          (pc_out),
        .valid_out       (valid_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        longint      due;
    } pend_t;

    typedef struct {
        logic [31:0] raddr;
        logic [31:0] exp_addr;
    } vec_t;

    pend_t       pend[$];
    logic [31:0] acc_log[$];
    int          n_checks = 0;
    int          n_fail = 0;
    int          n_valid = 0;
    longint      cyc = 0;
    logic [31:0] exp_pc = RPC;
    logic [31:0] exp_fetch = RPC;
    logic [31:0] last_valid_pc = '0;
    bit          hold_pending = 1'b0;
    logic [31:0] hold_addr = '0;

    function automatic logic [31:0] word(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h5A5A_1234;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock: called at a negedge, drives inputs, models memory, checks the result.
    task automatic do_cycle(input bit st, input bit rd, input logic [31:0] ra,
                            input bit rdy, input int lat);
        logic        o_v;
        logic [31:0] o_i, o_p, acc_addr;
        bit          acc, resp;
        longint      due;
        stall_in       = st;
        redirect_valid = rd;
        redirect_addr  = ra;
        imem_ready     = rdy;
        if (pend.size() > 0 && pend[0].due <= cyc + 1) begin
            imem_rvalid = 1'b1;
            imem_rdata  = word(pend[0].addr);
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = $urandom;
        end
        #1;
        if (rd) check("req_blocked_on_redirect", 32'(imem_req), 32'd0);
        if (hold_pending && !rd) begin
            check("req_held", 32'(imem_req), 32'd1);
            check("addr_held", imem_addr, hold_addr);
        end
        check("credit_cap", 32'(pend.size() <= QD), 32'd1);
        check("no_rvalid_into_full_queue",
              32'(imem_rvalid && (32'(dut.u_queue.count) == QD)), 32'd0);
        acc      = imem_req && imem_ready;
        acc_addr = imem_addr;
        resp     = imem_rvalid;
        if (acc) begin
            check("fetch_addr", acc_addr, exp_fetch);
            exp_fetch = exp_fetch + 32'd4;
            acc_log.push_back(acc_addr);
        end
        hold_pending = imem_req && !imem_ready;
        hold_addr    = imem_addr;
        o_v = valid_out;
        o_i = instruction_out;
        o_p = pc_out;
        @(posedge clk);
        cyc++;
        if (resp) pend.delete(0);
        if (acc) begin
            due = cyc + lat;
            if (pend.size() > 0 && pend[pend.size()-1].due > due) due = pend[pend.size()-1].due;
            pend.push_back('{addr: acc_addr, due: due});
        end
        if (rd) exp_fetch = {ra[31:2], 2'b00};
        @(negedge clk);
        if (rd) begin
            check("redir_valid", 32'(valid_out), 32'd0);
            check("redir_insn", instruction_out, NOP);
            exp_pc = {ra[31:2], 2'b00};
        end else if (st) begin
            check("stall_valid", 32'(valid_out), 32'(o_v));
            check("stall_insn", instruction_out, o_i);
            check("stall_pc", pc_out, o_p);
        end else if (valid_out) begin
            check("pc_seq", pc_out, exp_pc);
            check("insn", instruction_out, word(exp_pc));
            last_valid_pc = pc_out;
            exp_pc = exp_pc + 32'd4;
            n_valid++;
        end else begin
            check("bubble_insn", instruction_out, NOP);
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_valid", 32'(valid_out), 32'd0);
        check("rst_insn", instruction_out, NOP);
        check("rst_pc", pc_out, RPC);
        check("rst_req", 32'(imem_req), 32'd0);
        pend.delete();
        acc_log.delete();
        hold_pending = 1'b0;
        exp_pc = RPC;
        exp_fetch = RPC;
        imem_rvalid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic run_until_valid(input int budget, output bit got);
        int v0;
        v0 = n_valid;
        for (int k = 0; k < budget && n_valid == v0; k++) do_cycle(0, 0, '0, 1, 1);
        got = (n_valid != v0);
    endtask

    initial begin
        vec_t vecs[5];
        bit   got;
        int   first;

        vecs[0] = '{raddr: 32'h0000_0103, exp_addr: 32'h0000_0100};
        vecs[1] = '{raddr: 32'hFFFF_FFFF, exp_addr: 32'hFFFF_FFFC};
        vecs[2] = '{raddr: 32'h0000_0002, exp_addr: 32'h0000_0000};
        vecs[3] = '{raddr: 32'h1234_5678, exp_addr: 32'h1234_5678};
        vecs[4] = '{raddr: 32'h8000_0001, exp_addr: 32'h8000_0000};

        // Reset and first-word latency (accept, response, queue, output).
        apply_reset();
        first = 0;
        for (int k = 1; k <= 12; k++) begin
            do_cycle(0, 0, '0, 1, 1);
            if (first == 0 && n_valid > 0) first = k;
        end
        check("first_valid_edge", 32'(first), 32'd3);
        check("first_acc_addr", acc_log[0], RPC);

        // Stall: outputs hold, credit runs out, stream resumes without gaps.
        repeat (4) do_cycle(1, 0, '0, 1, 1);
        check("req_off_when_credit_full", 32'(imem_req), 32'd0);
        first = n_valid;
        repeat (10) do_cycle(0, 0, '0, 1, 1);
        check("resumed_after_stall", 32'(n_valid > first), 32'd1);

        // Redirect with two requests in flight: both responses discarded.
        for (int k = 0; k < 10 && pend.size() != 2; k++) do_cycle(0, 0, '0, 1, 3);
        check("two_outstanding", 32'(pend.size()), 32'd2);
        acc_log.delete();
        do_cycle(0, 1, 32'h0000_0103, 1, 1);
        run_until_valid(20, got);
        check("redir_got_valid", 32'(got), 32'd1);
        check("redir_first_pc", last_valid_pc, 32'h0000_0100);
        check("redir_first_acc", acc_log[0], 32'h0000_0100);

        // Table of redirect targets: alignment and first delivered PC.
        for (int i = 0; i < 5; i++) begin
            do_cycle(0, 1, vecs[i].raddr, 1, 1);
            check("tbl_imem_addr", imem_addr, vecs[i].exp_addr);
            run_until_valid(20, got);
            check("tbl_got_valid", 32'(got), 32'd1);
            check("tbl_first_pc", last_valid_pc, vecs[i].exp_addr);
        end

        // Toggling ready with 3-cycle latency.
        for (int k = 0; k < 40; k++) do_cycle(0, 0, '0, k[0], 3);

        // Address wrap at the top of memory.
        do_cycle(0, 1, 32'hFFFF_FFF8, 1, 1);
        acc_log.delete();
        repeat (8) do_cycle(0, 0, '0, 1, 1);
        check("wrap_acc_count", 32'(acc_log.size() >= 3), 32'd1);
        if (acc_log.size() >= 3) begin
            check("wrap_addr0", acc_log[0], 32'hFFFF_FFF8);
            check("wrap_addr1", acc_log[1], 32'hFFFF_FFFC);
            check("wrap_addr2", acc_log[2], 32'h0000_0000);
        end

        // Reset with requests outstanding, then resume from RESET_PC.
        repeat (3) do_cycle(0, 0, '0, 1, 3);
        check("outstanding_before_reset", 32'(pend.size() > 0), 32'd1);
        apply_reset();
        run_until_valid(20, got);
        check("post_reset_valid", 32'(got), 32'd1);
        check("post_reset_pc", last_valid_pc, RPC);

        // Randomized soak.
        for (int k = 0; k < 1500; k++) begin
            do_cycle(($urandom_range(0, 3) == 0), ($urandom_range(0, 19) == 0), $urandom,
                     ($urandom_range(0, 3) != 0), int'($urandom_range(1, 3)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
